pipe_adder: RTL and testbench

//   Parametrised, pipelined ripple-carry adder/subtractor with valid/ready flow control.
//   - Splits a WIDTH-bit add into STAGES chunks. Each pipeline stage resolves one CHUNK
//     (CHUNK = WIDTH/STAGES) and registers its carry into the next stage.
//   - Gives full throughput at high clock rate. Sits between operand-issue logic and

---
 rtl/pipe_adder.sv | 122 ++++++++++++
 tb/tb_pipe_adder.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_adder.sv
// pipe_adder: pipelined ripple-carry adder/subtractor, one CHUNK per stage, valid/ready flow control
module pipe_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4,
  parameter int TAG_W  = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_op1,
  input  logic [WIDTH-1:0] i_op2,
  input  logic             i_cin,
  input  logic             i_sub,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_ovf,
  output logic             o_zero,
  output logic [TAG_W-1:0] o_tag
);
  localparam int CHUNK = WIDTH / STAGES;
  localparam int CW = CHUNK + 1;
  logic [STAGES-1:0] v_q, v_d, c_q, c_d, acc;
  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] a_d [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] b_d [STAGES];
  logic [WIDTH-1:0] s_q [STAGES];
  logic [WIDTH-1:0] s_d [STAGES];
  logic [TAG_W-1:0] t_q [STAGES];
  logic [TAG_W-1:0] t_d [STAGES];
  logic ovf_q, ovf_d, zero_q, zero_d;
  logic nxt, pv, pc, cc, ld;
  logic [WIDTH-1:0] pa, pb, ps, sum;
  logic [TAG_W-1:0] pt;
  logic [CHUNK-1:0] chunk;
  // ready ripples from the output back to stage 0; an empty stage always accepts
  always_comb begin
    nxt = i_ready;
    acc = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      acc[k] = !v_q[k] || nxt;
      nxt = acc[k];
    end
  end
  // p* carry the view of the previous stage's register; stage 0 sees the transformed inputs
  always_comb begin
    pv = i_valid;
    pa = i_op1;
    pb = i_sub ? ~i_op2 : i_op2;
    pc = i_cin ^ i_sub;
    ps = '0;
    pt = i_tag;
    cc = 1'b0;
    chunk = '0;
    sum = '0;
    ld = 1'b0;
    v_d = v_q;
    c_d = c_q;
    a_d = a_q;
    b_d = b_q;
    s_d = s_q;
    t_d = t_q;
    ovf_d = ovf_q;
    zero_d = zero_q;
    for (int k = 0; k < STAGES; k++) begin
      {cc, chunk} = CW'(pa[k*CHUNK +: CHUNK]) + CW'(pb[k*CHUNK +: CHUNK]) + CW'(pc);
      sum = ps;
      sum[k*CHUNK +: CHUNK] = chunk;
      ld = acc[k] && pv;
      v_d[k] = acc[k] ? pv : v_q[k];
      c_d[k] = ld ? cc : c_q[k];
      a_d[k] = ld ? pa : a_q[k];
      b_d[k] = ld ? pb : b_q[k];
      s_d[k] = ld ? sum : s_q[k];
      t_d[k] = ld ? pt : t_q[k];
      if (k == STAGES - 1) begin
        ovf_d = ld ? (pa[WIDTH-1] == pb[WIDTH-1]) && (sum[WIDTH-1] != pa[WIDTH-1]) : ovf_q;
        zero_d = ld ? ~|sum : zero_q;
      end
      pv = v_q[k];
      pa = a_q[k];
      pb = b_q[k];
      pc = c_q[k];
      ps = s_q[k];
      pt = t_q[k];
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      v_q <= '0;
      c_q <= '0;
      ovf_q <= 1'b0;
      zero_q <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        t_q[k] <= '0;
      end
    end else begin
      v_q <= v_d;
      c_q <= c_d;
      ovf_q <= ovf_d;
      zero_q <= zero_d;
      a_q <= a_d;
      b_q <= b_d;
      s_q <= s_d;
      t_q <= t_d;
    end
  end
  assign o_ready = acc[0];
  assign o_valid = v_q[STAGES-1];
  assign o_sum = s_q[STAGES-1];
  assign o_cout = c_q[STAGES-1];
  assign o_ovf = ovf_q;
  assign o_zero = zero_q;
  assign o_tag = t_q[STAGES-1];
endmodule

// File: tb/tb_pipe_adder.sv
// tb_pipe_adder: directed and randomized checks of pipe_adder against a behavioural arithmetic model
module tb_pipe_adder;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1, i_valid = 1'b0, i_ready = 1'b1, cin = 1'b0, sub = 1'b0;
  logic [31:0] op1 = '0, op2 = '0;
  logic [3:0] tag = '0;
  logic o0_ready, o0_valid, o0_cout, o0_ovf, o0_zero;
  logic o1_ready, o1_valid, o1_cout, o1_ovf, o1_zero;
  logic o2_ready, o2_valid, o2_cout, o2_ovf, o2_zero;
  logic [31:0] o0_sum;
  logic [7:0] o1_sum;
  logic [23:0] o2_sum;
  logic [3:0] o0_tag, o1_tag, o2_tag;
  logic [39:0] o0_all;
  logic [15:0] o1_all;
  logic [31:0] o2_all;
  int errors = 0, checks = 0;
  assign o0_all = {o0_valid, o0_cout, o0_ovf, o0_zero, o0_tag, o0_sum};
  assign o1_all = {o1_valid, o1_cout, o1_ovf, o1_zero, o1_tag, o1_sum};
  assign o2_all = {o2_valid, o2_cout, o2_ovf, o2_zero, o2_tag, o2_sum};

  pipe_adder #(.WIDTH(32), .STAGES(4), .TAG_W(4)) u0 (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o0_ready), .i_op1(op1), .i_op2(op2),
    .i_cin(cin), .i_sub(sub), .i_tag(tag), .o_valid(o0_valid), .i_ready(i_ready), .o_sum(o0_sum),
    .o_cout(o0_cout), .o_ovf(o0_ovf), .o_zero(o0_zero), .o_tag(o0_tag));
  pipe_adder #(.WIDTH(8), .STAGES(1), .TAG_W(4)) u1 (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o1_ready), .i_op1(op1[7:0]), .i_op2(op2[7:0]),
    .i_cin(cin), .i_sub(sub), .i_tag(tag), .o_valid(o1_valid), .i_ready(i_ready), .o_sum(o1_sum),
    .o_cout(o1_cout), .o_ovf(o1_ovf), .o_zero(o1_zero), .o_tag(o1_tag));
  pipe_adder #(.WIDTH(24), .STAGES(3), .TAG_W(4)) u2 (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o2_ready), .i_op1(op1[23:0]), .i_op2(op2[23:0]),
    .i_cin(cin), .i_sub(sub), .i_tag(tag), .o_valid(o2_valid), .i_ready(i_ready), .o_sum(o2_sum),
    .o_cout(o2_cout), .o_ovf(o2_ovf), .o_zero(o2_zero), .o_tag(o2_tag));

  typedef struct {
    logic [31:0] s;
    logic c;
    logic v;
    logic z;
    logic [3:0] t;
  } exp_t;

  function automatic exp_t model(int w, logic [31:0] a, logic [31:0] b, logic c, logic s, logic [3:0] t);
    exp_t e;
    longint m, au, bu, sa, sb, r, sr, lim, ci;
    m = (longint'(1) << w) - 1;
    au = longint'(a) & m;
    bu = longint'(b) & m;
    ci = c ? 1 : 0;
    sa = ((au >> (w - 1)) & 1) != 0 ? au - (m + 1) : au;
    sb = ((bu >> (w - 1)) & 1) != 0 ? bu - (m + 1) : bu;
    if (s) begin
      r = au - bu - ci;
      e.c = au >= bu + ci;
      sr = sa - sb - ci;
    end else begin
      r = au + bu + ci;
      e.c = ((r >> w) & 1) != 0;
      sr = sa + sb + ci;
    end
    lim = longint'(1) << (w - 1);
    e.s = 32'(r & m);
    e.v = (sr >= lim) || (sr < -lim);
    e.z = (r & m) == 0;
    e.t = t;
    return e;
  endfunction

  function automatic logic [39:0] pk(exp_t e);
    return {1'b1, e.c, e.v, e.z, e.t, e.s};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic v, logic [31:0] a, logic [31:0] b, logic c, logic s, logic [3:0] t);
    i_valid = v;
    op1 = a;
    op2 = b;
    cin = c;
    sub = s;
    tag = t;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive(1'b1, $urandom, $urandom, 1'b1, 1'b0, 4'hF);
    tick;
    tick;
    rst = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b0, '0);
    #1;
    checks++;
    if (o0_all !== 40'h0) begin
      errors++;
      $display("FAIL reset_outputs got=%h exp=%h", o0_all, 40'h0);
    end
    checks++;
    if (o0_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got=%b exp=1", o0_ready);
    end
  endtask

  task automatic test_carry;
    i_ready = 1'b1;
    tick;
    drive(1'b1, 32'hFFFFFFFF, 32'h1, 1'b0, 1'b0, 4'd3);
    tick;
    drive(1'b0, '0, '0, 1'b0, 1'b0, '0);
    tick;
    tick;
    checks++;
    if (o0_valid !== 1'b0) begin
      errors++;
      $display("FAIL carry_early_valid got=%b exp=0", o0_valid);
    end
    tick;
    checks++;
    if (o0_all !== {1'b1, 1'b1, 1'b0, 1'b1, 4'd3, 32'h0}) begin
      errors++;
      $display("FAIL carry_result got=%h exp=%h", o0_all, {1'b1, 1'b1, 1'b0, 1'b1, 4'd3, 32'h0});
    end
  endtask

  task automatic test_overflow_sub;
    logic [31:0] ta [3] = '{32'h7FFFFFFF, 32'd5, 32'd7};
    logic [31:0] tb [3] = '{32'h1, 32'd7, 32'd5};
    logic [2:0] tcs [3] = '{3'b000, 3'b001, 3'b011};
    logic [39:0] te [3] = '{{4'b1010, 4'd1, 32'h80000000}, {4'b1000, 4'd2, 32'hFFFFFFFE},
                            {4'b1100, 4'd3, 32'h00000001}};
    for (int i = 0; i < 3; i++) begin
      tick;
      drive(1'b1, ta[i], tb[i], tcs[i][1], tcs[i][0], 4'(i + 1));
      tick;
      drive(1'b0, '0, '0, 1'b0, 1'b0, '0);
      tick;
      tick;
      tick;
      checks++;
      if (o0_all !== te[i]) begin
        errors++;
        $display("FAIL arith_%0d got=%h exp=%h", i, o0_all, te[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    exp_t e [8];
    logic [31:0] a [8];
    logic [31:0] b [8];
    logic [1:0] cs [8];
    for (int i = 0; i < 8; i++) begin
      a[i] = $urandom;
      b[i] = $urandom;
      cs[i] = 2'($urandom);
      e[i] = model(32, a[i], b[i], cs[i][1], cs[i][0], 4'(i));
    end
    i_ready = 1'b1;
    for (int s = 0; s < 14; s++) begin
      tick;
      if (s < 8) drive(1'b1, a[s], b[s], cs[s][1], cs[s][0], 4'(s));
      else drive(1'b0, '0, '0, 1'b0, 1'b0, '0);
      #1;
      checks++;
      if (o0_valid !== (s >= 4 && s < 12)) begin
        errors++;
        $display("FAIL stream_valid step=%0d got=%b exp=%b", s, o0_valid, s >= 4 && s < 12);
      end
      if (s >= 4 && s < 12) begin
        checks++;
        if (o0_all !== pk(e[s-4])) begin
          errors++;
          $display("FAIL stream_data step=%0d got=%h exp=%h", s, o0_all, pk(e[s-4]));
        end
      end
    end
  endtask

  task automatic test_backpressure;
    exp_t e [10];
    logic [31:0] a [10];
    logic [31:0] b [10];
    logic [1:0] cs [10];
    int n = 0, rcv = 0;
    for (int i = 0; i < 10; i++) begin
      a[i] = $urandom;
      b[i] = $urandom;
      cs[i] = 2'($urandom);
      e[i] = model(32, a[i], b[i], cs[i][1], cs[i][0], 4'(i + 5));
    end
    for (int s = 0; s < 60 && rcv < 10; s++) begin
      tick;
      i_ready = s >= 6;
      if (n < 10) drive(1'b1, a[n], b[n], cs[n][1], cs[n][0], 4'(n + 5));
      else drive(1'b0, '0, '0, 1'b0, 1'b0, '0);
      #1;
      if (s < 6) begin
        checks++;
        if (o0_ready !== (s < 4)) begin
          errors++;
          $display("FAIL bp_ready step=%0d got=%b exp=%b", s, o0_ready, s < 4);
        end
      end
      if (s == 4 || s == 5) begin
        checks++;
        if (o0_all !== pk(e[0])) begin
          errors++;
          $display("FAIL bp_hold step=%0d got=%h exp=%h", s, o0_all, pk(e[0]));
        end
      end
      if (o0_valid && i_ready) begin
        checks++;
        if (o0_all !== pk(e[rcv])) begin
          errors++;
          $display("FAIL bp_drain idx=%0d got=%h exp=%h", rcv, o0_all, pk(e[rcv]));
        end
        rcv++;
      end
      if (i_valid && o0_ready) n++;
    end
    checks++;
    if (rcv != 10) begin
      errors++;
      $display("FAIL bp_count got=%0d exp=10", rcv);
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0, '0);
    for (int s = 0; s < 6; s++) begin
      tick;
      checks++;
      if (o0_valid !== 1'b0) begin
        errors++;
        $display("FAIL bp_dup step=%0d got=%b exp=0", s, o0_valid);
      end
    end
  endtask

  task automatic test_reset_midflight;
    i_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      drive(1'b1, $urandom, $urandom, 1'b1, 1'b0, 4'hA + 4'(i));
    end
    tick;
    rst = 1'b1;
    drive(1'b1, 32'h12345678, 32'h1, 1'b0, 1'b0, 4'h9);
    tick;
    rst = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b0, '0);
    #1;
    checks++;
    if (o0_all !== 40'h0 || o0_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid got=%h ready=%b exp=%h ready=1", o0_all, o0_ready, 40'h0);
    end
    for (int s = 0; s < 8; s++) begin
      tick;
      checks++;
      if (o0_valid !== 1'b0) begin
        errors++;
        $display("FAIL rst_ghost step=%0d got=%b exp=0", s, o0_valid);
      end
    end
  endtask

  task automatic test_random;
    exp_t q0 [$];
    exp_t q1 [$];
    exp_t q2 [$];
    exp_t e;
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
    for (int s = 0; s < 6010; s++) begin
      tick;
      if (s < 6000) begin
        drive($urandom_range(3) != 0,
              $urandom_range(7) == 0 ? 32'hFFFFFFFF : $urandom_range(7) == 0 ? 32'h80000000 : $urandom,
              $urandom_range(7) == 0 ? 32'h0 : $urandom_range(7) == 0 ? 32'h7FFFFFFF : $urandom,
              1'($urandom), 1'($urandom), 4'($urandom));
        i_ready = (s % 500) > 460 ? 1'b0 : $urandom_range(3) != 0;
      end else begin
        drive(1'b0, '0, '0, 1'b0, 1'b0, '0);
        i_ready = 1'b1;
      end
      #1;
      if (o0_valid && i_ready) begin
        checks++;
        if (q0.size() == 0) begin
          errors++;
          $display("FAIL rnd_w32s4 unexpected result got=%h", o0_all);
        end else begin
          e = q0.pop_front();
          if (o0_all !== pk(e)) begin
            errors++;
            $display("FAIL rnd_w32s4 got=%h exp=%h", o0_all, pk(e));
          end
        end
      end
      if (o1_valid && i_ready) begin
        checks++;
        if (q1.size() == 0) begin
          errors++;
          $display("FAIL rnd_w8s1 unexpected result got=%h", o1_all);
        end else begin
          e = q1.pop_front();
          if (o1_all !== {1'b1, e.c, e.v, e.z, e.t, e.s[7:0]}) begin
            errors++;
            $display("FAIL rnd_w8s1 got=%h exp=%h", o1_all, {1'b1, e.c, e.v, e.z, e.t, e.s[7:0]});
          end
        end
      end
      if (o2_valid && i_ready) begin
        checks++;
        if (q2.size() == 0) begin
          errors++;
          $display("FAIL rnd_w24s3 unexpected result got=%h", o2_all);
        end else begin
          e = q2.pop_front();
          if (o2_all !== {1'b1, e.c, e.v, e.z, e.t, e.s[23:0]}) begin
            errors++;
            $display("FAIL rnd_w24s3 got=%h exp=%h", o2_all, {1'b1, e.c, e.v, e.z, e.t, e.s[23:0]});
          end
        end
      end
      if (i_valid && o0_ready) q0.push_back(model(32, op1, op2, cin, sub, tag));
      if (i_valid && o1_ready) q1.push_back(model(8, op1, op2, cin, sub, tag));
      if (i_valid && o2_ready) q2.push_back(model(24, op1, op2, cin, sub, tag));
    end
    checks++;
    if (q0.size() + q1.size() + q2.size() != 0) begin
      errors++;
      $display("FAIL rnd_leftover got=%0d/%0d/%0d exp=0/0/0", q0.size(), q1.size(), q2.size());
    end
  endtask

  initial begin
    test_reset;
    test_carry;
    test_overflow_sub;
    test_back_to_back;
    test_backpressure;
    test_reset_midflight;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
